// File: rtl/xctrl_p.sv
// xctrl_p: accumulator-style program controller.
// Fetches one instruction per cycle and executes accumulator (regA), pointer
// (regB) and carry (cs) operations. Supports wait states on the data bus, a
// return-address stack for CALL/RET, and a sticky fault on stack misuse.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc, instruction   program address out, {opcode[3:0], field[IMM_W-1:0]} in
//   data_sel/we/addr  external data request, write strobe, address
//   data_to_rd/wr     read data in (valid with data_ready), write data (regA)
//   data_ready        external access completes this cycle
//   stack_lvl, fault  return-stack occupancy, sticky over/underflow flag
//
// state   | meaning
// --------+----------------------------------------------------------
// S_RUN   | executing one instruction per cycle (may stall on the bus)
// S_FAULT | stack over/underflow seen; everything frozen until rst
module xctrl_p #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int PROG_ADDR_W = 10,
  parameter int IMM_W       = 16,
  parameter int PROG_BASE   = 0,
  parameter int RB_ADDR     = 1,
  parameter int RC_ADDR     = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [PROG_ADDR_W-1:0]           pc,
  input  logic [IMM_W+3:0]                 instruction,
  output logic                             data_sel,
  output logic                             data_we,
  output logic [ADDR_W-1:0]                data_addr,
  input  logic [DATA_W-1:0]                data_to_rd,
  output logic [DATA_W-1:0]                data_to_wr,
  input  logic                             data_ready,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_lvl,
  output logic                             fault
);
  localparam int LVL_W = $clog2(STACK_DEPTH+1);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_FAULT = 1'b1} state_t;
  typedef enum logic [3:0] {
    OP_ADDI = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_SHFT  = 4'h3,
    OP_AND  = 4'h4, OP_XOR  = 4'h5, OP_LDI  = 4'h6, OP_LDIH  = 4'h7,
    OP_RDW  = 4'h8, OP_WRW  = 4'h9, OP_RDWB = 4'hA, OP_WRWB  = 4'hB,
    OP_BEQI = 4'hC, OP_BNEQI = 4'hD, OP_CALL = 4'hE, OP_RET  = 4'hF
  } op_t;

  state_t                 state_q, state_d;
  logic [PROG_ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0]      rega_q, rega_d;
  logic [DATA_W-1:0]      regb_q, regb_d;
  logic                   cs_q, cs_d;
  logic [LVL_W-1:0]       lvl_q, lvl_d;
  logic [PROG_ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [PROG_ADDR_W-1:0] stack_d [STACK_DEPTH];

  op_t                    opcode;
  logic [IMM_W-1:0]       field;
  logic [DATA_W-1:0]      imm;
  logic [DATA_W-1:0]      rd;
  logic [ADDR_W-1:0]      acc_addr;
  logic                   is_access, is_write, hit_rb, hit_rc;
  logic                   run, ext_acc, stall;
  logic [PROG_ADDR_W-1:0] pc_inc, stack_top;

  always_comb begin
    opcode    = op_t'(instruction[IMM_W+3:IMM_W]);
    field     = instruction[IMM_W-1:0];
    imm       = {{(DATA_W-IMM_W){field[IMM_W-1]}}, field};
    acc_addr  = (opcode == OP_RDWB || opcode == OP_WRWB)
                ? regb_q[ADDR_W-1:0] + imm[ADDR_W-1:0]
                : field[ADDR_W-1:0];
    is_access = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_XOR,
                               OP_RDW, OP_WRW, OP_RDWB, OP_WRWB};
    is_write  = opcode inside {OP_WRW, OP_WRWB};
    hit_rb    = (acc_addr == ADDR_W'(RB_ADDR));
    hit_rc    = (acc_addr == ADDR_W'(RC_ADDR));
    rd        = hit_rb ? regb_q
              : hit_rc ? {{(DATA_W-1){1'b0}}, cs_q}
              : data_to_rd;
    run       = (state_q == S_RUN);
    ext_acc   = run && is_access && !hit_rb && !hit_rc;
    stall     = ext_acc && !data_ready;
    pc_inc    = pc_q + PROG_ADDR_W'(1);
    // Top of stack is the entry just below the occupancy level.
    stack_top = stack_q[0];
    for (int i = 0; i < STACK_DEPTH; i++)
      if (lvl_q == LVL_W'(i + 1)) stack_top = stack_q[i];
  end

  assign pc         = pc_q;
  assign data_sel   = ext_acc;
  assign data_we    = ext_acc && is_write;
  assign data_addr  = acc_addr;
  assign data_to_wr = rega_q;
  assign stack_lvl  = lvl_q;
  assign fault      = (state_q == S_FAULT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    cs_d    = cs_q;
    lvl_d   = lvl_q;
    stack_d = stack_q;
    if (run && !stall) begin
      pc_d = pc_inc;
      case (opcode)
        OP_ADDI: {cs_d, rega_d} = {1'b0, rega_q} + {1'b0, imm};
        OP_ADD:  {cs_d, rega_d} = {1'b0, rega_q} + {1'b0, rd};
        OP_SUB:  {cs_d, rega_d} = {1'b0, rega_q} - {1'b0, rd};
        OP_SHFT: begin
          if (field[IMM_W-1]) begin
            rega_d = {rega_q[DATA_W-2:0], 1'b0};
            cs_d   = rega_q[DATA_W-1];
          end else begin
            rega_d = {1'b0, rega_q[DATA_W-1:1]};
            cs_d   = rega_q[0];
          end
        end
        OP_AND:  rega_d = rega_q & rd;
        OP_XOR:  rega_d = rega_q ^ rd;
        OP_LDI:  rega_d = imm;
        OP_LDIH: rega_d = {imm[DATA_W-IMM_W-1:0], rega_q[IMM_W-1:0]};
        OP_RDW, OP_RDWB: rega_d = rd;
        OP_WRW, OP_WRWB: begin
          if (hit_rb)      regb_d = rega_q;
          else if (hit_rc) cs_d   = rega_q[0];
        end
        OP_BEQI: begin
          rega_d = rega_q - DATA_W'(1);
          if (rega_q == '0) pc_d = pc_q + imm[PROG_ADDR_W-1:0];
        end
        OP_BNEQI: begin
          rega_d = rega_q - DATA_W'(1);
          if (rega_q != '0) pc_d = pc_q + imm[PROG_ADDR_W-1:0];
        end
        OP_CALL: begin
          if (lvl_q == LVL_W'(STACK_DEPTH)) begin
            state_d = S_FAULT;
            pc_d    = pc_q;
          end else begin
            for (int i = 0; i < STACK_DEPTH; i++)
              if (lvl_q == LVL_W'(i)) stack_d[i] = pc_inc;
            lvl_d = lvl_q + LVL_W'(1);
            pc_d  = field[PROG_ADDR_W-1:0];
          end
        end
        OP_RET: begin
          if (lvl_q == '0) begin
            state_d = S_FAULT;
            pc_d    = pc_q;
          end else begin
            pc_d  = stack_top;
            lvl_d = lvl_q - LVL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= PROG_ADDR_W'(PROG_BASE);
      rega_q  <= '0;
      regb_q  <= '0;
      cs_q    <= 1'b0;
      lvl_q   <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      cs_q    <= cs_d;
      lvl_q   <= lvl_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: tb/tb_xctrl_p.sv
module tb_xctrl_p;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pc;
  logic [19:0] instruction;
  logic        data_sel, data_we;
  logic [11:0] data_addr;
  logic [31:0] data_to_rd, data_to_wr;
  logic        data_ready;
  logic [2:0]  stack_lvl;
  logic        fault;

  logic [19:0] prog [0:1023];
  int n_chk = 0;
  int n_fail = 0;

  assign instruction = prog[pc];

  always #5 clk = ~clk;

  xctrl_p dut (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
    .data_sel(data_sel), .data_we(data_we), .data_addr(data_addr),
    .data_to_rd(data_to_rd), .data_to_wr(data_to_wr), .data_ready(data_ready),
    .stack_lvl(stack_lvl), .fault(fault)
  );

  function automatic logic [19:0] ins(input logic [3:0] op, input logic [15:0] f);
    return {op, f};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds rst over one edge with an all-NOP (ADDI 0) program; caller fills prog.
  task automatic start_reset();
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) prog[i] = 20'h0_0000;
    step(1);
  endtask

  task automatic release_reset();
    rst = 1'b0;
  endtask

  int cnt, n;

  initial begin
    data_ready = 1'b0;
    data_to_rd = 32'h0;

    // Reset values
    start_reset();
    step(1);
    check("rst_pc", pc, 10'h000);
    check("rst_lvl", stack_lvl, 3'd0);
    check("rst_fault", fault, 1'b0);
    check("rst_rega", data_to_wr, 32'h0);
    check("rst_sel", data_sel, 1'b0);

    // Countdown loop: LDI 5; ADDI 0; BNEQI -1
    start_reset();
    prog[0] = ins(4'h6, 16'h0005);
    prog[1] = ins(4'h0, 16'h0000);
    prog[2] = ins(4'hD, 16'hFFFF);
    release_reset();
    cnt = 0; n = 0;
    while (pc !== 10'd3 && n < 50) begin
      if (pc === 10'd2) cnt++;
      step(1);
      n++;
    end
    check("loop_bneqi_count", cnt, 6);
    check("loop_cycles", n, 13);
    check("loop_rega", data_to_wr, 32'hFFFF_FFFF);
    step(1);
    check("loop_exit_pc", pc, 10'd4);

    // Carry / borrow
    start_reset();
    prog[0] = ins(4'h6, 16'hFFFF);
    prog[1] = ins(4'h0, 16'h0001);
    prog[2] = ins(4'h8, 16'h0002);
    prog[3] = ins(4'h9, 16'h0001);
    prog[4] = ins(4'h6, 16'h0000);
    prog[5] = ins(4'h2, 16'h0001);
    prog[6] = ins(4'h8, 16'h0002);
    prog[7] = ins(4'h0, 16'h0000);
    prog[8] = ins(4'h8, 16'h0002);
    release_reset();
    step(1);
    check("ldi_neg1", data_to_wr, 32'hFFFF_FFFF);
    step(1);
    check("addi_wrap", data_to_wr, 32'h0);
    step(1);
    check("addi_carry", data_to_wr, 32'h1);
    step(3);
    check("sub_borrow_val", data_to_wr, 32'hFFFF_FFFF);
    step(1);
    check("sub_borrow_cs", data_to_wr, 32'h1);
    step(1);
    check("addi_nocarry_val", data_to_wr, 32'h1);
    step(1);
    check("addi_nocarry_cs", data_to_wr, 32'h0);

    // Wait-state read
    start_reset();
    prog[0] = ins(4'h6, 16'h0007);
    prog[1] = ins(4'h8, 16'h0100);
    prog[2] = ins(4'h0, 16'h0000);
    release_reset();
    step(1);
    for (int i = 0; i < 3; i++) begin
      check("stall_sel", data_sel, 1'b1);
      check("stall_addr", data_addr, 12'h100);
      step(1);
      check("stall_pc", pc, 10'd1);
      check("stall_rega", data_to_wr, 32'h7);
    end
    data_ready = 1'b1;
    data_to_rd = 32'hA5;
    check("stall_sel4", data_sel, 1'b1);
    check("stall_we", data_we, 1'b0);
    step(1);
    data_ready = 1'b0;
    check("rdw_done_pc", pc, 10'd2);
    check("rdw_done_rega", data_to_wr, 32'hA5);
    check("nop_sel", data_sel, 1'b0);
    step(1);
    check("nop_ignores_ready", pc, 10'd3);

    // regB / regC internal access, relative addressing, external write
    start_reset();
    data_ready = 1'b1;
    data_to_rd = 32'h1234;
    prog[0] = ins(4'h6, 16'h0040);
    prog[1] = ins(4'h9, 16'h0001);
    prog[2] = ins(4'hA, 16'h0002);
    prog[3] = ins(4'h6, 16'h0001);
    prog[4] = ins(4'h9, 16'h0002);
    prog[5] = ins(4'h8, 16'h0002);
    prog[6] = ins(4'hB, 16'hFFFF);
    prog[7] = ins(4'h8, 16'h0001);
    release_reset();
    step(1);
    check("wrw_rb_sel", data_sel, 1'b0);
    step(1);
    check("rdwb_addr", data_addr, 12'h042);
    check("rdwb_sel", data_sel, 1'b1);
    check("rdwb_we", data_we, 1'b0);
    step(1);
    check("rdwb_rega", data_to_wr, 32'h1234);
    step(1);
    check("wrw_rc_sel", data_sel, 1'b0);
    step(1);
    check("rdw_rc_sel", data_sel, 1'b0);
    step(1);
    check("wrw_rc_cs", data_to_wr, 32'h1);
    check("wrwb_addr", data_addr, 12'h03F);
    check("wrwb_sel", data_sel, 1'b1);
    check("wrwb_we", data_we, 1'b1);
    step(1);
    check("wrwb_pc", pc, 10'd7);
    step(1);
    check("rdw_rb", data_to_wr, 32'h40);
    data_ready = 1'b0;

    // CALL / RET, nested
    start_reset();
    prog[10'h10] = ins(4'hE, 16'h0020);
    prog[10'h20] = ins(4'hE, 16'h0030);
    prog[10'h30] = ins(4'hF, 16'h0000);
    prog[10'h21] = ins(4'hF, 16'h0000);
    release_reset();
    step(16);
    check("call_start_pc", pc, 10'h010);
    step(1);
    check("call1_pc", pc, 10'h020);
    check("call1_lvl", stack_lvl, 3'd1);
    step(1);
    check("call2_pc", pc, 10'h030);
    check("call2_lvl", stack_lvl, 3'd2);
    step(1);
    check("ret1_pc", pc, 10'h021);
    check("ret1_lvl", stack_lvl, 3'd1);
    step(1);
    check("ret2_pc", pc, 10'h011);
    check("ret2_lvl", stack_lvl, 3'd0);
    check("ret2_fault", fault, 1'b0);

    // Overflow fault and reset recovery
    start_reset();
    for (int i = 0; i < 5; i++) prog[i] = {4'hE, 16'(i + 1)};
    release_reset();
    step(4);
    check("ovf_lvl4", stack_lvl, 3'd4);
    check("ovf_nofault", fault, 1'b0);
    step(1);
    check("ovf_fault", fault, 1'b1);
    check("ovf_pc", pc, 10'd4);
    check("ovf_lvl_hold", stack_lvl, 3'd4);
    step(3);
    check("ovf_pc_frozen", pc, 10'd4);
    check("ovf_still_fault", fault, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_fault_pc", pc, 10'd0);
    check("rst_fault_clr", fault, 1'b0);
    check("rst_fault_lvl", stack_lvl, 3'd0);

    // Underflow: RET at level 0, then a frozen external access is not requested
    start_reset();
    prog[0] = ins(4'hF, 16'h0000);
    release_reset();
    step(1);
    check("udf_fault", fault, 1'b1);
    check("udf_pc", pc, 10'd0);
    prog[0] = ins(4'h8, 16'h0100);
    step(2);
    check("udf_no_sel", data_sel, 1'b0);
    check("udf_pc_frozen", pc, 10'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
